// File: rtl/chicken_pkg.sv
// Shared constants, FSM state type and helpers for the chicken race board.
package chicken_pkg;

  localparam int TILES       = 24;
  localparam int PIC_W       = 4;
  localparam int MAX_PLAYERS = 4;
  localparam logic [2:0] TAIL_MAX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FLIP,
    ST_FETCH,
    ST_COMPARE,
    ST_END_TURN,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // Player-count code to number of players; the illegal code yields 0.
  function automatic logic [2:0] player_count(input logic [1:0] code);
    case (code)
      2'b00:   return 3'd2;
      2'b01:   return 3'd3;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Advance a board position by k tiles, wrapping at the board length.
  function automatic logic [4:0] wrap_add(input logic [4:0] pos, input logic [2:0] k,
                                          input int tiles = TILES);
    logic [5:0] sum;
    sum = {1'b0, pos} + {3'b000, k};
    if (int'(sum) >= tiles) sum = sum - 6'(tiles);
    return sum[4:0];
  endfunction

endpackage

// File: rtl/board_tile_rom.sv
// Board picture ROM: one picture id per tile, registered (1-cycle) read.
// Tile t carries picture (t + 1) truncated to PIC_W bits.
module board_tile_rom #(
  parameter int PIC_W = chicken_pkg::PIC_W
) (
  input  logic             clk,
  input  logic [4:0]       addr,
  output logic [PIC_W-1:0] pic
);
  import chicken_pkg::*;

  logic [PIC_W-1:0] rom_mem [TILES];

  genvar gi;
  generate
    for (gi = 0; gi < TILES; gi++) begin : g_fill
      assign rom_mem[gi] = PIC_W'(gi + 1);
    end
  endgenerate

  // Registered read; addresses past the board return picture 0.
  always_ff @(posedge clk) begin
    pic <= (int'(addr) < TILES) ? rom_mem[addr] : '0;
  end

endmodule

// File: rtl/turn_controller.sv
// Per-turn controller: accepts card flips, looks up the tile ahead in the
// board ROM, moves/jumps the current chicken or hands the turn on.
module turn_controller #(
  parameter int TILES = chicken_pkg::TILES,
  parameter int PIC_W = chicken_pkg::PIC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       num_players,
  input  logic [1:0]       turn,
  input  logic             flip_valid,
  input  logic [PIC_W-1:0] flip_pic,
  output logic [4:0]       tile_addr,
  input  logic [PIC_W-1:0] tile_pic,
  output logic             next_turn,
  output logic [4:0]       pos0,
  output logic [4:0]       pos1,
  output logic [4:0]       pos2,
  output logic [4:0]       pos3,
  output logic [2:0]       tails0,
  output logic [2:0]       tails1,
  output logic [2:0]       tails2,
  output logic [2:0]       tails3,
  output logic             game_over,
  output logic [1:0]       winner
);
  import chicken_pkg::*;

  state_t           state_reg, state_next;
  logic [4:0]       pos_reg   [MAX_PLAYERS];
  logic [4:0]       pos_next  [MAX_PLAYERS];
  logic [2:0]       tails_reg [MAX_PLAYERS];
  logic [2:0]       tails_next[MAX_PLAYERS];
  logic [2:0]       count_reg, count_next;
  logic [PIC_W-1:0] pic_reg, pic_next;
  logic [4:0]       target_reg, target_next;
  logic [3:0]       jumped_reg, jumped_next;
  logic [4:0]       tile_addr_reg, tile_addr_next;
  logic             next_turn_reg, next_turn_next;
  logic             game_over_reg, game_over_next;
  logic [1:0]       winner_reg, winner_next;

  logic [3:0]       is_active;
  logic [3:0]       occ;
  logic [3:0]       search_mask;
  logic [4:0]       search_tgt;
  logic [4:0]       gain_sum;
  logic [2:0]       gain_sat;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PLAYERS; gi++) begin : g_active
      assign is_active[gi] = (3'(gi) < count_reg);
    end
  endgenerate

  // Landing tile for the current player: hop over up to three other active chickens.
  always_comb begin
    search_mask = '0;
    occ         = '0;
    search_tgt  = wrap_add(pos_reg[turn], 3'd1, TILES);
    for (int step = 0; step < MAX_PLAYERS - 1; step++) begin
      occ = '0;
      for (int p = 0; p < MAX_PLAYERS; p++) begin
        if (is_active[p] && (2'(p) != turn) && (pos_reg[p] == search_tgt)) occ[p] = 1'b1;
      end
      if (|occ) begin
        search_mask = search_mask | occ;
        search_tgt  = wrap_add(search_tgt, 3'd1, TILES);
      end
    end
  end

  // Tails the current player would hold after collecting every jumped player's tails.
  always_comb begin
    gain_sum = {2'b00, tails_reg[turn]};
    for (int p = 0; p < MAX_PLAYERS; p++) begin
      if (jumped_reg[p]) gain_sum = gain_sum + {2'b00, tails_reg[p]};
    end
    gain_sat = (gain_sum > {2'b00, TAIL_MAX}) ? TAIL_MAX : gain_sum[2:0];
  end

  // Next-state and next-register logic for the turn FSM.
  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    tails_next     = tails_reg;
    count_next     = count_reg;
    pic_next       = pic_reg;
    target_next    = target_reg;
    jumped_next    = jumped_reg;
    tile_addr_next = tile_addr_reg;
    next_turn_next = 1'b0;
    game_over_next = game_over_reg;
    winner_next    = winner_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start && (num_players != 2'b11)) begin
          count_next = player_count(num_players);
          for (int p = 0; p < MAX_PLAYERS; p++) begin
            pos_next[p]   = 5'(6 * p);
            tails_next[p] = (3'(p) < count_next) ? 3'd1 : 3'd0;
          end
          game_over_next = 1'b0;
          state_next     = ST_WAIT_FLIP;
        end
      end
      ST_WAIT_FLIP: begin
        if (flip_valid) begin
          pic_next       = flip_pic;
          target_next    = search_tgt;
          jumped_next    = search_mask;
          tile_addr_next = search_tgt;
          state_next     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The ROM address is already registered; its data arrives next cycle.
        state_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (tile_pic == pic_reg) begin
          pos_next[turn] = target_reg;
          for (int p = 0; p < MAX_PLAYERS; p++) begin
            if (jumped_reg[p]) tails_next[p] = 3'd0;
          end
          tails_next[turn] = gain_sat;
          if (gain_sat == count_reg) begin
            winner_next    = turn;
            game_over_next = 1'b1;
            state_next     = ST_DONE;
          end else begin
            state_next = ST_WAIT_FLIP;
          end
        end else begin
          next_turn_next = 1'b1;
          state_next     = ST_END_TURN;
        end
      end
      ST_END_TURN: state_next = ST_SETTLE;
      ST_SETTLE:   state_next = ST_WAIT_FLIP;
      default:     state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset reloads the starting board layout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      for (int p = 0; p < MAX_PLAYERS; p++) begin
        pos_reg[p]   <= 5'(6 * p);
        tails_reg[p] <= (3'(p) < player_count(num_players)) ? 3'd1 : 3'd0;
      end
      count_reg     <= player_count(num_players);
      pic_reg       <= '0;
      target_reg    <= '0;
      jumped_reg    <= '0;
      tile_addr_reg <= '0;
      next_turn_reg <= 1'b0;
      game_over_reg <= 1'b0;
      winner_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      tails_reg     <= tails_next;
      count_reg     <= count_next;
      pic_reg       <= pic_next;
      target_reg    <= target_next;
      jumped_reg    <= jumped_next;
      tile_addr_reg <= tile_addr_next;
      next_turn_reg <= next_turn_next;
      game_over_reg <= game_over_next;
      winner_reg    <= winner_next;
    end
  end

  assign tile_addr = tile_addr_reg;
  assign next_turn = next_turn_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;
  assign pos0      = pos_reg[0];
  assign pos1      = pos_reg[1];
  assign pos2      = pos_reg[2];
  assign pos3      = pos_reg[3];
  assign tails0    = tails_reg[0];
  assign tails1    = tails_reg[1];
  assign tails2    = tails_reg[2];
  assign tails3    = tails_reg[3];

endmodule
